// File: rtl/tdc_meas_seq_pkg.sv
// Shared types for the TDC measurement sequencer: control-line encoding, run
// configuration, sequencer state and small formatting helpers.
package tdc_meas_seq_pkg;

    localparam int TDC_CODE_W  = 8;
    localparam int TDC_NSAMP_W = 4;
    localparam int TDC_ACC_W   = TDC_CODE_W + TDC_NSAMP_W;

    typedef enum logic [1:0] {
        PG_IN  = 2'd0,
        PG_TOG = 2'd1,
        PG_EXT = 2'd2
    } pg_src_t;

    typedef enum logic {
        BYPASS = 1'b0,
        REG    = 1'b1
    } tdc_mode_t;

    typedef struct packed {
        pg_src_t   pg_src;
        tdc_mode_t mode;
    } ctrl_lines;

    localparam ctrl_lines CTL_RESET = '{pg_src: PG_IN, mode: BYPASS};

    typedef struct packed {
        ctrl_lines                ctl;
        logic [TDC_NSAMP_W-1:0]   nsamp;
    } meas_cfg_t;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_SETTLE = S_SETTLE,
        ST_LAUNCH = S_LAUNCH,
        ST_WAIT   = S_WAIT,
        ST_DONE   = S_DONE
    } seq_state_t;

    function automatic string print_ctl_line_status(input ctrl_lines c);
        return $sformatf("ctl pg_src=%s mode=%s", c.pg_src.name(), c.mode.name());
    endfunction

    function automatic string print_meas_result(
        input logic [TDC_ACC_W-1:0]   sum,
        input logic [TDC_CODE_W-1:0]  min_code,
        input logic [TDC_CODE_W-1:0]  max_code,
        input logic [TDC_NSAMP_W-1:0] nvalid,
        input logic [TDC_NSAMP_W-1:0] nmiss
    );
        return $sformatf("meas sum=%0d min=%0d max=%0d nvalid=%0d nmiss=%0d",
                         sum, min_code, max_code, nvalid, nmiss);
    endfunction

endpackage

// File: rtl/tdc_meas_seq_timer.sv
// Loadable down-counter shared by the settle and response-timeout phases.
// o_expired marks the last counted cycle (count==1) so a load of N spans N cycles.
module tdc_seq_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/tdc_meas_seq.sv
// Measurement sequencer: latches a run configuration, drives the TDC control
// lines, settles, launches N pulses and accumulates sum/min/max/miss statistics.
module tdc_meas_seq
    import tdc_meas_seq_pkg::*;
#(
    parameter int CODE_W      = TDC_CODE_W,
    parameter int NSAMP_W     = TDC_NSAMP_W,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  meas_cfg_t                 cfg_i,
    input  logic                      abort_i,
    input  logic                      ack_i,
    output ctrl_lines                 ctl_o,
    output logic                      launch_o,
    input  logic                      code_valid_i,
    input  logic [CODE_W-1:0]         code_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [CODE_W+NSAMP_W-1:0] sum_o,
    output logic [CODE_W-1:0]         min_o,
    output logic [CODE_W-1:0]         max_o,
    output logic [NSAMP_W-1:0]        nvalid_o,
    output logic [NSAMP_W-1:0]        nmiss_o,
    output seq_state_t                dbg_state_o
);

    localparam int ACC_W   = CODE_W + NSAMP_W;
    // Settle is loaded with one extra cycle so the first launch lands SETTLE_CYC+1 after start.
    localparam int TMR_MAX = (SETTLE_CYC + 1 > TIMEOUT_CYC) ? SETTLE_CYC + 1 : TIMEOUT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    seq_state_t          r_state;
    seq_state_t          w_next;
    ctrl_lines           r_ctl;
    logic [NSAMP_W-1:0]  r_nsamp;
    logic [ACC_W-1:0]    r_sum;
    logic [CODE_W-1:0]   r_min;
    logic [CODE_W-1:0]   r_max;
    logic [NSAMP_W-1:0]  r_nvalid;
    logic [NSAMP_W-1:0]  r_nmiss;

    logic                w_busy;
    logic                w_accept;
    logic                w_abort;
    logic                w_code_ok;
    logic                w_miss;
    logic                w_resolve;
    logic                w_last;
    logic [NSAMP_W:0]    w_resolved_cnt;
    logic                w_tmr_load;
    logic [TMR_W-1:0]    w_tmr_val;
    logic                w_tmr_exp;

    tdc_seq_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expired  (w_tmr_exp)
    );

    assign w_busy    = (r_state == ST_SETTLE) || (r_state == ST_LAUNCH) || (r_state == ST_WAIT);
    assign w_accept  = (r_state == ST_IDLE) && start_i;
    assign w_abort   = w_busy && abort_i;
    // A valid in the expiry cycle wins over the timeout.
    assign w_code_ok = (r_state == ST_WAIT) && code_valid_i && !abort_i;
    assign w_miss    = (r_state == ST_WAIT) && w_tmr_exp && !code_valid_i && !abort_i;
    assign w_resolve = w_code_ok || w_miss;

    assign w_resolved_cnt = {1'b0, r_nvalid} + {1'b0, r_nmiss} + {{NSAMP_W{1'b0}}, 1'b1};
    assign w_last         = (w_resolved_cnt == {1'b0, r_nsamp});

    always_comb begin
        w_next     = r_state;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (cfg_i.nsamp == '0) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next     = ST_SETTLE;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = TMR_W'(SETTLE_CYC + 1);
                    end
                end
            end
            ST_SETTLE: begin
                if (w_tmr_exp) w_next = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                w_next     = ST_WAIT;
                w_tmr_load = 1'b1;
                w_tmr_val  = TMR_W'(TIMEOUT_CYC);
            end
            ST_WAIT: begin
                if (w_resolve) w_next = w_last ? ST_DONE : ST_LAUNCH;
            end
            ST_DONE: begin
                if (ack_i) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_abort) begin
            w_next     = ST_IDLE;
            w_tmr_load = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Results and configuration only change on an accepted start or a resolved WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctl    <= CTL_RESET;
            r_nsamp  <= '0;
            r_sum    <= '0;
            r_min    <= '1;
            r_max    <= '0;
            r_nvalid <= '0;
            r_nmiss  <= '0;
        end else if (w_accept) begin
            r_ctl    <= cfg_i.ctl;
            r_nsamp  <= NSAMP_W'(cfg_i.nsamp);
            r_sum    <= '0;
            r_min    <= '1;
            r_max    <= '0;
            r_nvalid <= '0;
            r_nmiss  <= '0;
        end else if (w_code_ok) begin
            r_sum    <= r_sum + ACC_W'(code_i);
            r_nvalid <= r_nvalid + 1'b1;
            if (code_i < r_min) r_min <= code_i;
            if (code_i > r_max) r_max <= code_i;
        end else if (w_miss) begin
            r_nmiss  <= r_nmiss + 1'b1;
        end
    end

    assign ctl_o       = r_ctl;
    assign launch_o    = (r_state == ST_LAUNCH) && !abort_i;
    assign busy_o      = w_busy;
    assign done_o      = (r_state == ST_DONE);
    assign sum_o       = r_sum;
    assign min_o       = r_min;
    assign max_o       = r_max;
    assign nvalid_o    = r_nvalid;
    assign nmiss_o     = r_nmiss;
    assign dbg_state_o = r_state;

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, r_nvalid} + {1'b0, r_nmiss}) <= {1'b0, r_nsamp});

endmodule

// File: tb/tb_tdc_meas_seq.sv
// Directed bench for tdc_meas_seq: a small datapath responder returns codes a
// fixed number of cycles after each launch; results are compared to hand values.
module tb_tdc_meas_seq;
    import tdc_meas_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        ack_i = 1'b0;
    logic        code_valid_i = 1'b0;
    logic [7:0]  code_i = 8'd0;
    meas_cfg_t   cfg_i = '0;
    ctrl_lines   ctl_o;
    logic        launch_o, busy_o, done_o;
    logic [11:0] sum_o;
    logic [7:0]  min_o, max_o;
    logic [3:0]  nvalid_o, nmiss_o;
    seq_state_t  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int launch_cnt = 0;
    int done_cnt = 0;
    int resp_delay = 3;
    bit resp_en = 1'b0;
    logic [7:0] code_q[$];

    tdc_meas_seq #(
        .CODE_W(8), .NSAMP_W(4), .SETTLE_CYC(4), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .cfg_i(cfg_i), .abort_i(abort_i),
        .ack_i(ack_i), .ctl_o(ctl_o), .launch_o(launch_o), .code_valid_i(code_valid_i),
        .code_i(code_i), .busy_o(busy_o), .done_o(done_o), .sum_o(sum_o), .min_o(min_o),
        .max_o(max_o), .nvalid_o(nvalid_o), .nmiss_o(nmiss_o), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (launch_o) launch_cnt++;
        if (done_o) done_cnt++;
    end

    // Datapath model: code strobe resp_delay cycles after the launch cycle.
    always begin
        @(negedge clk);
        if (launch_o && resp_en) begin
            repeat (resp_delay) @(posedge clk);
            #1;
            code_valid_i = 1'b1;
            code_i = (code_q.size() > 0) ? code_q.pop_front() : 8'h00;
            @(posedge clk);
            #1;
            code_valid_i = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic meas_cfg_t mk_cfg(input pg_src_t p, input tdc_mode_t m, input int n);
        meas_cfg_t c;
        c.ctl.pg_src = p;
        c.ctl.mode   = m;
        c.nsamp      = 4'(n);
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input meas_cfg_t c);
        cfg_i   = c;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic do_ack();
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
    endtask

    task automatic cycles_until_launch(input string tag, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!launch_o && n < 100);
        if (!launch_o) check_eq({tag, "_launch_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n = 0;
        while (!done_o && n < maxc) begin
            step();
            n++;
        end
        check_eq({tag, "_done"}, 32'(done_o), 1);
    endtask

    task automatic check_res(input string tag, input int s, input int mn, input int mx,
                             input int nv, input int nm);
        check_eq({tag, "_sum"}, 32'(sum_o), s);
        check_eq({tag, "_min"}, 32'(min_o), mn);
        check_eq({tag, "_max"}, 32'(max_o), mx);
        check_eq({tag, "_nvalid"}, 32'(nvalid_o), nv);
        check_eq({tag, "_nmiss"}, 32'(nmiss_o), nm);
    endtask

    initial begin
        int n;
        int lc0;
        int dc0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("rst_ctl", 32'(ctl_o), 32'({PG_IN, BYPASS}));
        check_eq("rst_launch", 32'(launch_o), 0);
        check_eq("rst_busy", 32'(busy_o), 0);
        check_eq("rst_done", 32'(done_o), 0);
        check_res("rst", 0, 255, 0, 0, 0);
        rst = 1'b0;
        step();

        // Four samples, all answered three cycles after launch
        code_q = '{8'd10, 8'd20, 8'd5, 8'd30};
        resp_delay = 3;
        resp_en = 1'b1;
        lc0 = launch_cnt;
        do_start(mk_cfg(PG_TOG, REG, 4));
        check_eq("t1_ctl_at_start", 32'(ctl_o), 32'({PG_TOG, REG}));
        check_eq("t1_busy", 32'(busy_o), 1);
        cycles_until_launch("t1", n);
        check_eq("t1_first_launch_latency", n, 5);
        wait_done("t1", 200);
        check_res("t1", 65, 5, 30, 4, 0);
        check_eq("t1_launches", launch_cnt - lc0, 4);
        $display("t1 %s", print_meas_result(sum_o, min_o, max_o, nvalid_o, nmiss_o));
        do_ack();
        check_eq("t1_idle_after_ack", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("t1_held_sum", 32'(sum_o), 65);

        // Zero samples: straight to DONE, no launch
        lc0 = launch_cnt;
        do_start(mk_cfg(PG_TOG, BYPASS, 0));
        check_eq("t3_done_next", 32'(done_o), 1);
        check_eq("t3_busy", 32'(busy_o), 0);
        check_eq("t3_ctl", 32'(ctl_o), 32'({PG_TOG, BYPASS}));
        check_res("t3", 0, 255, 0, 0, 0);
        repeat (3) step();
        check_eq("t3_no_launch", launch_cnt - lc0, 0);
        check_eq("t3_done_held", 32'(done_o), 1);
        do_ack();
        check_eq("t3_idle_after_ack", 32'(dbg_state), 32'(ST_IDLE));

        // Three samples, datapath silent: every WAIT times out
        resp_en = 1'b0;
        lc0 = launch_cnt;
        do_start(mk_cfg(PG_EXT, BYPASS, 3));
        cycles_until_launch("t2a", n);
        cycles_until_launch("t2b", n);
        check_eq("t2_launch_gap", n, 17);
        wait_done("t2", 100);
        check_res("t2", 0, 255, 0, 0, 3);
        check_eq("t2_launches", launch_cnt - lc0, 3);
        do_ack();

        // Abort during the second WAIT
        code_q = '{8'd10, 8'd99};
        resp_delay = 3;
        resp_en = 1'b1;
        lc0 = launch_cnt;
        dc0 = done_cnt;
        do_start(mk_cfg(PG_TOG, REG, 5));
        cycles_until_launch("t4a", n);
        cycles_until_launch("t4b", n);
        step();
        check_eq("t4_in_wait", 32'(dbg_state), 32'(ST_WAIT));
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check_eq("t4_idle_after_abort", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("t4_busy", 32'(busy_o), 0);
        check_eq("t4_ctl_kept", 32'(ctl_o), 32'({PG_TOG, REG}));
        repeat (6) step();
        check_res("t4", 10, 10, 10, 1, 0);
        check_eq("t4_no_done", done_cnt - dc0, 0);
        check_eq("t4_launches", launch_cnt - lc0, 2);

        // Fifteen max codes, each arriving in the exact timeout cycle
        code_q.delete();
        for (int i = 0; i < 15; i++) code_q.push_back(8'd255);
        resp_delay = 16;
        do_start(mk_cfg(PG_IN, REG, 15));
        wait_done("t5", 400);
        check_res("t5", 3825, 255, 255, 15, 0);
        do_ack();

        // start_i while busy and in DONE with ack_i is ignored
        code_q = '{8'd7, 8'd9};
        resp_delay = 3;
        do_start(mk_cfg(PG_TOG, BYPASS, 2));
        cycles_until_launch("t6", n);
        step();
        cfg_i = mk_cfg(PG_EXT, REG, 7);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check_eq("t6_ctl_busy_start", 32'(ctl_o), 32'({PG_TOG, BYPASS}));
        wait_done("t6", 100);
        check_res("t6", 16, 7, 9, 2, 0);
        cfg_i = mk_cfg(PG_EXT, REG, 7);
        start_i = 1'b1;
        ack_i = 1'b1;
        step();
        start_i = 1'b0;
        ack_i = 1'b0;
        check_eq("t6_idle_after_ack", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("t6_ctl_after_ack", 32'(ctl_o), 32'({PG_TOG, BYPASS}));
        step();
        check_eq("t6_still_idle", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("t6_sum_held", 32'(sum_o), 16);

        // Asynchronous reset in the middle of a run
        code_q = '{8'd50, 8'd60, 8'd70, 8'd80};
        do_start(mk_cfg(PG_TOG, REG, 4));
        cycles_until_launch("t7", n);
        repeat (5) step();
        check_eq("t7_pre_rst_nvalid", 32'(nvalid_o), 1);
        resp_en = 1'b0;
        #2;
        rst = 1'b1;
        #2;
        check_eq("t7_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("t7_rst_ctl", 32'(ctl_o), 32'({PG_IN, BYPASS}));
        check_eq("t7_rst_busy", 32'(busy_o), 0);
        check_eq("t7_rst_launch", 32'(launch_o), 0);
        check_res("t7_rst", 0, 255, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) step();
        check_eq("t7_idle_after_rst", 32'(dbg_state), 32'(ST_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
